// File: rtl/fetch_stage_if.sv
// fetch_stage_if: memory request/response, execute redirect and decode handshake
// bundle for the instruction-fetch stage.
`default_nettype none

interface fetch_stage_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output id_valid, instruction, pc, pred_taken, pred_target,
      input  id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  id_valid, instruction, pc, pred_taken, pred_target,
      output id_ready
   );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch with credit-limited requests, instruction buffer
// and redirect flush. Optional backward-taken branch prediction: FETCH_BTFN_PREDICT_EN.
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rstn,
   fetch_stage_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   logic [31:0] fetch_pc_q, fetch_pc_d;
   cnt_t        outst_q, outst_d;
   cnt_t        drop_q, drop_d;
   cnt_t        fifo_cnt_q, fifo_cnt_d;
   ptr_t        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   ptr_t        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
   logic [31:0] tag_mem_q [FIFO_DEPTH];
   entry_t      fifo_mem_q [FIFO_DEPTH];

   logic        tag_push, fifo_push;
   logic [CW:0] credit_used;
   logic        req_fire, rsp_keep, pop;
   logic [31:0] tag_pc;
   logic        pred_hit;
   logic [31:0] pred_target;
   logic        unused_rp_bits;

   // Credits cover both in-flight words and buffered words, so the buffer never overflows.
   assign credit_used        = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
   assign bus.imem_req_valid = rstn && !bus.redirect_valid && (credit_used < DEPTH_C);
   assign bus.imem_req_addr  = fetch_pc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_keep           = bus.imem_rsp_valid && (drop_q == '0);
   assign tag_pc             = tag_mem_q[tag_rd_q];
   assign pop                = bus.id_valid && bus.id_ready;
   assign unused_rp_bits     = ^bus.redirect_pc[1:0];

`ifdef FETCH_BTFN_PREDICT_EN
   logic [31:0] b_imm;
   assign b_imm = {{19{bus.imem_rsp_data[31]}}, bus.imem_rsp_data[31], bus.imem_rsp_data[7],
                   bus.imem_rsp_data[30:25], bus.imem_rsp_data[11:8], 1'b0};
   assign pred_hit    = rsp_keep && (bus.imem_rsp_data[6:0] == 7'b1100011) && bus.imem_rsp_data[31];
   assign pred_target = tag_pc + b_imm;
`else
   assign pred_hit    = 1'b0;
   assign pred_target = '0;
`endif

   assign bus.id_valid    = (fifo_cnt_q != '0);
   assign bus.instruction = fifo_mem_q[fifo_rd_q].insn;
   assign bus.pc          = fifo_mem_q[fifo_rd_q].pc;
   assign bus.pred_taken  = fifo_mem_q[fifo_rd_q].taken;
   assign bus.pred_target = fifo_mem_q[fifo_rd_q].target;

   always_comb begin
      fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
      outst_d    = outst_q + cnt_t'(req_fire) - cnt_t'(bus.imem_rsp_valid);
      drop_d     = (bus.imem_rsp_valid && drop_q != '0) ? drop_q - cnt_t'(1) : drop_q;
      tag_push   = req_fire;
      fifo_push  = rsp_keep;
      tag_wr_d   = req_fire ? tag_wr_q + ptr_t'(1) : tag_wr_q;
      tag_rd_d   = rsp_keep ? tag_rd_q + ptr_t'(1) : tag_rd_q;
      fifo_wr_d  = rsp_keep ? fifo_wr_q + ptr_t'(1) : fifo_wr_q;
      fifo_rd_d  = pop ? fifo_rd_q + ptr_t'(1) : fifo_rd_q;
      fifo_cnt_d = fifo_cnt_q + cnt_t'(rsp_keep) - cnt_t'(pop);
      // Predicted branch keeps its own entry; every younger fetch (incl. this cycle's) is dropped.
      if (pred_hit) begin
         fetch_pc_d = pred_target;
         drop_d     = outst_d;
         tag_push   = 1'b0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
      end
      if (bus.redirect_valid) begin
         fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
         drop_d     = outst_d;
         tag_push   = 1'b0;
         fifo_push  = 1'b0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
         fifo_wr_d  = '0;
         fifo_rd_d  = '0;
         fifo_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         fifo_cnt_q <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         fifo_wr_q  <= '0;
         fifo_rd_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            tag_mem_q[i]  <= '0;
            fifo_mem_q[i] <= '{insn: NOP, pc: 32'h0, taken: 1'b0, target: 32'h0};
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         fifo_cnt_q <= fifo_cnt_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_rd_q  <= fifo_rd_d;
         if (tag_push)
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
         if (fifo_push)
            fifo_mem_q[fifo_wr_q] <= '{insn: bus.imem_rsp_data, pc: tag_pc,
                                       taken: pred_hit, target: pred_target};
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-programmable memory model.
`default_nettype none

module tb_fetch_stage;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if bus();

   fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus.master)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        taken;
      logic [31:0] tgt;
   } id_t;

   id_t         exp_id[$];
   logic [31:0] exp_addr[$];
   int          n_vec   = 0;
   int          n_err   = 0;
   int          credits = 0;
   int          acc_cnt = 0;
   int unsigned lat     = 1;
   int unsigned cyc     = 0;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      if (a == 32'h40) return 32'hFE00_0EE3;
      return {a[23:0], 8'h13};
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Memory model: accepts under a credit budget, answers in order after 'lat' cycles.
   initial begin : mem
      logic [31:0] p_addr[$];
      int unsigned p_due[$];
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (rstn && bus.imem_req_valid && bus.imem_req_ready) begin
            p_addr.push_back(bus.imem_req_addr);
            p_due.push_back(cyc + lat);
            credits--;
            acc_cnt++;
            if (exp_addr.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL req_addr: unexpected request to %h", bus.imem_req_addr);
            end else begin
               check("req_addr", bus.imem_req_addr, exp_addr.pop_front());
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!rstn) begin
            p_addr.delete();
            p_due.delete();
         end
         bus.imem_req_ready = (credits > 0);
         if (p_addr.size() != 0 && p_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(p_addr.pop_front());
            void'(p_due.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
      end
   end

   initial begin : mon
      id_t e;
      forever begin
         @(negedge clk);
         if (rstn && bus.id_valid && bus.id_ready) begin
            if (exp_id.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL id_out: unexpected pc=%h insn=%h", bus.pc, bus.instruction);
            end else begin
               e = exp_id.pop_front();
               check("id_pc", bus.pc, e.pc);
               check("id_insn", bus.instruction, e.insn);
               check("id_taken", 32'(bus.pred_taken), 32'(e.taken));
               check("id_target", bus.pred_target, e.tgt);
            end
         end
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_fetch(logic [31:0] a, logic ta = 1'b0, logic [31:0] tg = 32'h0);
      exp_addr.push_back(a);
      exp_id.push_back('{pc: a, insn: mem_word(a), taken: ta, tgt: tg});
   endtask

   task automatic drain(string name);
      int t = 0;
      while ((exp_id.size() != 0 || exp_addr.size() != 0 || credits > 0) && t < 300) begin
         tick();
         t++;
      end
      n_vec++;
      if (t >= 300) begin
         n_err++;
         $display("FAIL %s_timeout: %0d ids and %0d addrs still expected", name,
                  exp_id.size(), exp_addr.size());
      end
      tick(3);
   endtask

   task automatic redirect(logic [31:0] p);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = p;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(string tag);
      @(negedge clk);
      check({tag, "_id_valid"}, 32'(bus.id_valid), 32'h0);
      check({tag, "_insn"}, bus.instruction, 32'h0000_0013);
      check({tag, "_pc"}, bus.pc, 32'h0);
      check({tag, "_taken"}, 32'(bus.pred_taken), 32'h0);
      check({tag, "_target"}, bus.pred_target, 32'h0);
      check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int          acc0;
      int          t;
      logic [31:0] nxt;
      bus.id_ready       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      tick(3);
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check("rst_req_addr", bus.imem_req_addr, 32'h0);
      check("rst_req_valid_after", 32'(bus.imem_req_valid), 32'h1);

      // Sequential stream, single-cycle memory, decode always ready.
      @(posedge clk);
      #1;
      bus.id_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_fetch(32'(i * 4));
      credits = 8;
      drain("seq");

      // Decode stall: only two fetches may be in flight or buffered, head held.
      bus.id_ready = 1'b0;
      acc0 = acc_cnt;
      for (int i = 0; i < 5; i++) exp_fetch(32'h20 + 32'(i * 4));
      credits = 5;
      tick(6);
      check("stall_inflight", 32'(acc_cnt - acc0), 32'd2);
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", 32'(bus.id_valid), 32'h1);
         check("stall_pc", bus.pc, 32'h20);
         check("stall_insn", bus.instruction, mem_word(32'h20));
      end
      @(posedge clk);
      #1;
      bus.id_ready = 1'b1;
      drain("stall");

      // Redirect with two slow responses outstanding: both must be dropped.
      lat = 4;
      exp_addr.push_back(32'h34);
      exp_addr.push_back(32'h38);
      credits = 2;
      t = 0;
      while (credits > 0 && t < 50) begin
         tick();
         t++;
      end
      check("redir_issue_two", 32'(credits), 32'h0);
      redirect(32'h100);
      lat = 1;
      for (int i = 0; i < 3; i++) exp_fetch(32'h100 + 32'(i * 4));
      credits = 3;
      drain("redirect");

      // Low address bits ignored; fetch PC wraps past the top of the address space.
      redirect(32'h0000_0203);
      exp_fetch(32'h200);
      credits = 1;
      drain("redir_align");
      redirect(32'hFFFF_FFFE);
      exp_fetch(32'hFFFF_FFFC);
      exp_fetch(32'h0);
      credits = 2;
      drain("wrap");

      // Backward branch at 0x40 (B-imm = -4).
      redirect(32'h40);
`ifdef FETCH_BTFN_PREDICT_EN
      exp_fetch(32'h40, 1'b1, 32'h3C);
      exp_addr.push_back(32'h44);
      exp_fetch(32'h3C);
      credits = 3;
      nxt = 32'h40;
`else
      exp_fetch(32'h40, 1'b0, 32'h0);
      exp_fetch(32'h44);
      credits = 2;
      nxt = 32'h48;
`endif
      drain("btfn");

      // Reset with a full buffer.
      bus.id_ready = 1'b0;
      exp_fetch(nxt);
      exp_fetch(nxt + 32'd4);
      credits = 2;
      tick(6);
      check("pre_reset_valid", 32'(bus.id_valid), 32'h1);
      rstn = 1'b0;
      exp_addr.delete();
      exp_id.delete();
      credits = 0;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check("midrst_req_addr", bus.imem_req_addr, 32'h0);
      @(posedge clk);
      #1;
      bus.id_ready = 1'b1;
      exp_fetch(32'h0);
      credits = 1;
      drain("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
